mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative integer multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator, one step per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     opnd, a_orig;
  logic                 is_div, a_neg, b_neg, b_zero;

  logic                 accept, write_mt;
  logic [WIDTH-1:0]     a_mag_in, b_mag_in;
  logic                 a_neg_in, b_neg_in;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign accept   = (state == IDLE) && start && !flush && !op[2];
  assign write_mt = (state == IDLE) && start && !flush && (op[2:1] == 2'b10);

  // Unsigned ops (odd op codes) never flag operands as negative.
  assign a_neg_in = !op[0] && A[WIDTH-1];
  assign b_neg_in = !op[0] && B[WIDTH-1];
  assign a_mag_in = a_neg_in ? -A : A;
  assign b_mag_in = b_neg_in ? -B : B;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (flush) state_next = IDLE;
               else if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // One iteration: lower half holds multiplier bits / dividend bits shifting into quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (is_div)
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction; a zero divisor bypasses the datapath result entirely.
  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_lo = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, a_mag_in};
            opnd   <= b_mag_in;
            a_orig <= A;
            is_div <= op[1];
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            b_zero <= (B == '0);
          end
          if (write_mt) begin
            if (op[0]) LO <= A;
            else       HI <= A;
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            HI   <= fix_hi;
            LO   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;

  logic        start8, flush8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .flush(flush), .busy(busy), .done(done), .HI(hi), .LO(lo)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .flush(flush8), .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int n, bc;
    model(o, x, y, eh, el);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) bc++;
    end
    check({tag, ".latency"}, 64'(n), 64'd33);
    check({tag, ".busy_cycles"}, 64'(bc), 64'd33);
    check({tag, ".HI"}, 64'(hi), 64'(eh));
    check({tag, ".LO"}, 64'(lo), 64'(el));
    $display("%s op=%0d A=%h B=%h HI=%h LO=%h", tag, o, x, y, hi, lo);
    tick();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [31:0] x, y, sh, sl, eh, el;
  logic [2:0]  o;
  int          n, nd;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.HI", 64'(hi), 64'd0);
    check("reset.LO", 64'(lo), 64'd0);

    // Directed cases
    run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu_neg7by2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu_by0", 3'd3, 32'h1234_5678, 32'h0000_0000);
    run_op("div_by0", 3'd2, 32'h8765_4321, 32'h0000_0000);
    run_op("div_minby_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", o, x, y);
    end

    // MTHI / MTLO, no-op, and flushed start
    op = 3'd4; a = 32'hAAAA_0001; start = 1'b1;
    tick();
    op = 3'd5; a = 32'hBBBB_0002;
    tick();
    start = 1'b0;
    check("mthi.HI", 64'(hi), 64'hAAAA_0001);
    check("mtlo.LO", 64'(lo), 64'hBBBB_0002);
    check("mt.done", 64'(done), 64'd0);
    check("mt.busy", 64'(busy), 64'd0);
    op = 3'd6; a = 32'h1111_1111; start = 1'b1;
    tick();
    op = 3'd4; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("noop.HI", 64'(hi), 64'hAAAA_0001);
    check("noop.LO", 64'(lo), 64'hBBBB_0002);
    check("noop.busy", 64'(busy), 64'd0);
    $display("mt_noop HI=%h LO=%h", hi, lo);

    // Flush during CALC
    op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("flush_calc.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc.busy", 64'(busy), 64'd0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done) nd++;
    end
    check("flush_calc.no_done", 64'(nd), 64'd0);
    check("flush_calc.HI", 64'(hi), 64'hAAAA_0001);
    check("flush_calc.LO", 64'(lo), 64'hBBBB_0002);
    $display("flush_calc HI=%h LO=%h", hi, lo);
    op = 3'd5; a = 32'h0000_0055; start = 1'b1;
    tick();
    start = 1'b0;
    check("mtlo55.LO", 64'(lo), 64'h55);

    // Flush on the FIX edge
    op = 3'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("flush_fix.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_fix.done", 64'(done), 64'd0);
    check("flush_fix.busy", 64'(busy), 64'd0);
    check("flush_fix.HI", 64'(hi), 64'hAAAA_0001);
    check("flush_fix.LO", 64'(lo), 64'h55);
    $display("flush_fix HI=%h LO=%h", hi, lo);

    // Starts while busy are ignored, including MTHI
    x = 32'hFFFF_FF85; y = 32'h0001_0003;
    model(3'd0, x, y, eh, el);
    op = 3'd0; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = 3'd2; a = 32'd99; b = 32'd5; start = 1'b1;
    tick();
    op = 3'd4; a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("ignore.busy", 64'(busy), 64'd1);
    check("ignore.HI_mid", 64'(hi), 64'hAAAA_0001);
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    check("ignore.latency", 64'(n), 64'd27);
    check("ignore.HI", 64'(hi), 64'(eh));
    check("ignore.LO", 64'(lo), 64'(el));
    $display("ignore_busy HI=%h LO=%h", hi, lo);
    tick();
    check("ignore.no_second", 64'(busy), 64'd0);

    // Reset mid-operation
    sh = hi; sl = lo;
    op = 3'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.HI", 64'(hi), 64'd0);
    check("rst_mid.LO", 64'(lo), 64'd0);
    $display("reset_mid prevHI=%h prevLO=%h HI=%h LO=%h", sh, sl, hi, lo);
    nd = 0;
    repeat (20) begin tick(); if (done) nd++; end
    check("rst_mid.no_done", 64'(nd), 64'd0);

    // WIDTH=8 instance
    op8 = 3'd0; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin tick(); n++; end
    check("w8.latency", 64'(n), 64'd9);
    check("w8.HI", 64'(hi8), 64'h40);
    check("w8.LO", 64'(lo8), 64'h00);
    $display("w8 mult A=80 B=80 HI=%h LO=%h", hi8, lo8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
